// File: rtl/filter_pkg.sv
// Shared beat types for the range filter / lane packer front end.
// Default-sized types; the top re-derives them locally for its own parameters.
package filter_pkg;

    localparam int LANES_DEFAULT     = 4;
    localparam int BIT_WIDTH_DEFAULT = 32;

    typedef logic [LANES_DEFAULT-1:0][BIT_WIDTH_DEFAULT-1:0] lane_data_t;
    typedef logic [LANES_DEFAULT-1:0]                        keep_mask_t;

    typedef struct packed {
        lane_data_t data;
        keep_mask_t keep;
    } beat_t;

endpackage

// File: rtl/lane_beat_reg.sv
// Single-entry valid/ready output register for packed beats.
// slot_free tells the producer a load this cycle will not overwrite a live beat.
module lane_beat_reg
    import filter_pkg::*;
#(
    parameter type beat_type = beat_t
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  beat_type beat_in,
    output beat_type beat,
    output logic     valid,
    input  logic     ready,
    output logic     slot_free
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            beat  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            beat  <= beat_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

    assign slot_free = !valid || ready;

endmodule

// File: rtl/range_filter_packer.sv
// Packs a scalar stream into LANES-wide beats with per-lane range keep bits.
// Beats with no kept lanes are dropped; seen/kept counters saturate.
module range_filter_packer
    import filter_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int LANES       = LANES_DEFAULT,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    input  logic [BIT_WIDTH-1:0]   cfg_lo,
    input  logic [BIT_WIDTH-1:0]   cfg_hi,
    input  logic                   in_valid,
    input  logic [BIT_WIDTH-1:0]   in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [BIT_WIDTH-1:0]   out_data [0:LANES-1],
    output logic [LANES-1:0]       out_keep,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] seen_count,
    output logic [COUNT_WIDTH-1:0] kept_count
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [LANES-1:0][BIT_WIDTH-1:0] data_arr_t;
    typedef struct packed {
        data_arr_t        data;
        logic [LANES-1:0] keep;
    } beat_local_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    logic [BIT_WIDTH-1:0] lo, hi;
    logic [IDX_W-1:0]     idx;
    logic                 full;
    beat_local_t          asm_beat, comp_beat, load_beat, out_beat;
    logic                 accept, match, complete, drain_pending, slot_free, load;

    always_comb begin
        accept    = in_valid && !full;
        match     = (lo <= in_data) && (in_data <= hi);
        comp_beat = asm_beat;
        comp_beat.data[idx] = in_data;
        comp_beat.keep[idx] = match;
        complete      = accept && (in_last || (idx == IDX_W'(LANES - 1)));
        drain_pending = full && out_valid && out_ready;
        // A parked beat always takes the slot first; no accept can race it.
        load      = drain_pending || (complete && (|comp_beat.keep) && slot_free);
        load_beat = full ? asm_beat : comp_beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo         <= '0;
            hi         <= '1;
            idx        <= '0;
            full       <= 1'b0;
            asm_beat   <= '0;
            seen_count <= '0;
            kept_count <= '0;
        end else begin
            if (cfg_valid) begin
                lo <= cfg_lo;
                hi <= cfg_hi;
            end
            if (accept) begin
                seen_count <= sat_inc(seen_count);
                if (match) kept_count <= sat_inc(kept_count);
                if (complete) begin
                    idx <= '0;
                    if ((|comp_beat.keep) && !slot_free) begin
                        asm_beat <= comp_beat;
                        full     <= 1'b1;
                    end else begin
                        asm_beat <= '0;
                    end
                end else begin
                    idx      <= idx + IDX_W'(1);
                    asm_beat <= comp_beat;
                end
            end else if (drain_pending) begin
                asm_beat <= '0;
                full     <= 1'b0;
            end
        end
    end

    lane_beat_reg #(
        .beat_type(beat_local_t)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .beat_in  (load_beat),
        .beat     (out_beat),
        .valid    (out_valid),
        .ready    (out_ready),
        .slot_free(slot_free)
    );

    assign in_ready = !full;
    assign out_keep = out_beat.keep;

    always_comb begin
        for (int i = 0; i < LANES; i++) out_data[i] = out_beat.data[i];
    end

endmodule

// File: doc/range_filter_packer.md
Name: range_filter_packer

Overview:
- Upstream feeder for the lane-compacting FIFO stage.
- Accepts a scalar stream of unsigned values and packs consecutive items into LANES-wide beats.
- Tags each lane with a keep bit from an inclusive range test [lo, hi]. The downstream stage compacts kept lanes.
- Beats with no kept lanes are dropped here, so they never consume a downstream cycle. Running seen/kept statistics are maintained.

Parameters:
- BIT_WIDTH, 32, width of each data item and of the range bounds.
- LANES, 4, lanes per output beat; must be >0 and even (matches the downstream MAX_INPUTS).
- COUNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  load new range bounds this cycle
- cfg_lo  in  BIT_WIDTH  inclusive lower bound
- cfg_hi  in  BIT_WIDTH  inclusive upper bound
- in_valid  in  1  scalar item valid
- in_data  in  BIT_WIDTH  scalar item
- in_last  in  1  item ends a group; flush the partial beat
- in_ready  out  1  block can accept an item
- out_valid  out  1  beat valid
- out_data  out  LANES x BIT_WIDTH (unpacked array [0:LANES-1])  lane data
- out_keep  out  LANES  per-lane keep mask
- out_ready  in  1  downstream accepts beat
- seen_count  out  COUNT_WIDTH  items accepted since reset
- kept_count  out  COUNT_WIDTH  items with keep=1 since reset

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_valid=0, out_data all 0, out_keep=0, in_ready=1.
  - Counters 0; lane index 0; assembly keep bits 0.
  - lo=0, hi=all ones, i.e. pass-all.
- Reset mid-beat discards the partial assembly and any held output beat.
- Range regs:
  - On cfg_valid, lo/hi update at the clock edge.
  - An item accepted in the same cycle uses the OLD bounds.
  - lo>hi is legal and matches nothing.
- Match: keep = (lo <= in_data) && (in_data <= hi), unsigned compare, combinational at accept.
- Accept: in_valid && in_ready.
  - Write the item into assembly lane idx and set keep[idx].
  - seen_count += 1; kept_count += keep. Both counters saturate at all-ones.
- Lane placement:
  - Item goes to lane idx regardless of keep.
  - Unfilled lanes of a flushed beat have data 0 and keep 0.
- Beat completion: on accept when idx==LANES-1 or in_last=1. idx then returns to 0, otherwise idx+1.
- Completion hand-off:
  - The completed beat's mask includes the completing item.
  - Mask all-zero: the beat is discarded; no output, no stall.
  - Else, if the output slot is free (!out_valid, or out_valid && out_ready this cycle), load the output regs next edge and assert out_valid.
  - Else set assembly_full; in_ready=0 until the beat moves. It moves on the first edge where out_ready && out_valid, and becomes the new output in that same edge, giving a zero-bubble swap.
- in_ready = !assembly_full, a registered signal with no combinational path from out_ready.
- Output beat stays stable while out_valid && !out_ready.
- Latency: completing accept at edge N gives out_valid high after edge N.
- Throughput: one item per cycle sustained while out_ready=1.
- in_last with idx==LANES-1 produces one beat, not two.
- Simultaneous completion and output drain: the load wins and out_valid stays 1.

Decomposition:
- Package filter_pkg:
  - LANES default.
  - typedef for a lane data array and a keep mask.
  - typedef struct beat_t {data, keep}.
- Sub-module lane_beat_reg:
  - Single-entry valid/ready output register holding beat_t.
  - Load/drain semantics as specified; provides the slot-free signal.
- The top level holds the assembly buffer, lane index, range regs, match logic and counters.

Test Plan:
- Reset, pass-all bounds; stream 1,2,3,4 (last on 4) with out_ready=1 -> one beat data {1,2,3,4}, keep 4'b1111, out_valid one cycle after 4th accept; seen=4, kept=4.
- cfg lo=10, hi=20; stream 5,10,20,21 -> beat {5,10,20,21}, keep 4'b0110; kept=2.
- Bounds 10..20; stream 1,2,3,4 -> no beat emitted, in_ready stays 1; seen=4, kept=0.
- Pass-all; stream 7,8 with last on 8 -> beat {7,8,0,0}, keep 4'b0011; next item lands in lane 0.
- out_ready=0, stream 8 pass items -> first beat held stable, second completes, in_ready falls to 0. Raise out_ready -> beats 1 then 2 delivered back-to-back, in_ready returns to 1.
- cfg_valid to 0..0 in the same cycle as accepting item 5 under pass-all -> item 5 keep=1; subsequent item 5 keep=0. Assert rst mid-beat -> outputs and counters at reset values, next item lands in lane 0.
